alu_8_bit: RTL and testbench
============================

Name: alu_8_bit

Overview:
- 8-bit, 16-function arithmetic/logic unit with a registered result and a registered carry-out flag.
- Two 8-bit operands are combined according to a 4-bit function select.
- The result is captured on the rising clock edge.
- Used as a leaf datapath block; purely feed-forward, with no handshake and no internal state beyond the output registers.

Parameters:
- None. Data width is fixed at 8 and select width at 4.

Ports:
- clk  input  1  system clock, rising-edge active
- rst_n  input  1  asynchronous active-low reset
- A  input  8  operand A, unsigned
- B  input  8  operand B, unsigned
- ALU_Sel  input  4  function select
- ALU_Out  output  8  registered result
- CarryOut  output  1  registered carry flag

Behaviour:
- Clocking and reset
  - One clock (clk).
  - Reset rst_n is asynchronous and active-low.
  - While rst_n=0: ALU_Out=8'h00 and CarryOut=0, immediately and independent of clk.
  - Release of reset takes effect at the next rising clk edge.
- Latency
  - On each rising clk with rst_n=1, ALU_Out <= f(A,B,ALU_Sel) and CarryOut <= carry, both evaluated from inputs sampled at that edge.
  - Latency is exactly 1 cycle. A new operation is accepted every cycle.
- Function table (all arithmetic unsigned; results truncated to the low 8 bits):
  - 0000 ADD: A+B
  - 0001 SUB: A-B, modulo 256
  - 0010 MUL: low 8 bits of A*B
  - 0011 DIV: A/B, integer quotient; if B=0 the result is 8'hFF
  - 0100 SHL: A<<1, zero fill
  - 0101 SHR: A>>1, zero fill
  - 0110 ROL: {A[6:0],A[7]}
  - 0111 ROR: {A[0],A[7:1]}
  - 1000 AND: A&B
  - 1001 OR: A|B
  - 1010 XOR: A^B
  - 1011 NOR: ~(A|B)
  - 1100 NAND: ~(A&B)
  - 1101 XNOR: ~(A^B)
  - 1110 GT: 8'h01 if A>B, else 8'h00
  - 1111 EQ: 8'h01 if A==B, else 8'h00
- CarryOut
  - Always bit 8 of the 9-bit sum {1'b0,A}+{1'b0,B}, for every ALU_Sel value, not only ADD.
- Boundary conditions
  - All 16 select codes are defined; there are no illegal codes.
  - SUB underflow wraps (e.g. 00-01 = FF); CarryOut still reflects A+B.
  - MUL overflow is silently truncated.
  - DIV by zero gives FF with no error flag.
  - Inputs that change between edges have no effect until the next edge.
  - Reset asserted mid-stream clears both outputs at once; the first result after reset release appears one edge after release.

Test Plan:
- Reset: hold rst_n=0 with A=AA, B=55 and toggle clk -> ALU_Out=00, CarryOut=0. Release rst_n, apply ALU_Sel=0000 -> after 1 edge ALU_Out=FF, CarryOut=0.
- Sweep with A=AA, B=55, one select per cycle, 0000..1111 -> ALU_Out sequence FF,55,72,02,54,55,55,55,00,FF,FF,00,FF,00,01,00, each one cycle after its select; CarryOut=0 throughout.
- Carry: A=FF, B=01, ALU_Sel=0000 -> ALU_Out=00, CarryOut=1. Same operands with ALU_Sel=1000 -> ALU_Out=01, CarryOut=1.
- Edge arithmetic:
  - A=00, B=01, SUB -> FF
  - A=10, B=10, MUL -> 00
  - A=37, B=00, DIV -> FF
  - A=81, ROL -> 03; A=81, ROR -> C0
- Compare: A=B=5A gives GT=00, EQ=01. A=5B, B=5A gives GT=01, EQ=00.
- Async reset mid-stream: during the sweep, drop rst_n between clock edges -> outputs go to 00/0 without waiting for a clk edge. Release -> normal results resume one edge later.

Source files
------------

// File: rtl/alu_8_bit.sv
// alu_8_bit: 8-bit, 16-function ALU with registered result and registered A+B carry flag
module alu_8_bit (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] A,
    input  logic [7:0] B,
    input  logic [3:0] ALU_Sel,
    output logic [7:0] ALU_Out,
    output logic       CarryOut
);

    logic [7:0] result;
    logic [8:0] sum;
    logic [7:0] product;

    assign sum     = {1'b0, A} + {1'b0, B};
    assign product = A * B;

    // Combinational function select; the carry flag is always the A+B carry regardless of select
    always_comb begin
        result = 8'h00;
        case (ALU_Sel)
            4'b0000: result = sum[7:0];
            4'b0001: result = A - B;
            4'b0010: result = product;
            4'b0011: result = (B == 8'h00) ? 8'hFF : A / B;
            4'b0100: result = {A[6:0], 1'b0};
            4'b0101: result = {1'b0, A[7:1]};
            4'b0110: result = {A[6:0], A[7]};
            4'b0111: result = {A[0], A[7:1]};
            4'b1000: result = A & B;
            4'b1001: result = A | B;
            4'b1010: result = A ^ B;
            4'b1011: result = ~(A | B);
            4'b1100: result = ~(A & B);
            4'b1101: result = ~(A ^ B);
            4'b1110: result = (A > B) ? 8'h01 : 8'h00;
            default: result = (A == B) ? 8'h01 : 8'h00;
        endcase
    end

    // Output registers, cleared immediately by the asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ALU_Out  <= 8'h00;
            CarryOut <= 1'b0;
        end else begin
            ALU_Out  <= result;
            CarryOut <= sum[8];
        end
    end

endmodule

// File: tb/tb_alu_8_bit.sv
// tb_alu_8_bit: scoreboard-based self-checking bench for alu_8_bit
module tb_alu_8_bit;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] A = 8'h00;
    logic [7:0] B = 8'h00;
    logic [3:0] ALU_Sel = 4'h0;
    logic [7:0] ALU_Out;
    logic       CarryOut;

    int checks = 0;
    int failures = 0;
    logic [8:0] sb[$];

    alu_8_bit dut (
        .clk(clk), .rst_n(rst_n), .A(A), .B(B),
        .ALU_Sel(ALU_Sel), .ALU_Out(ALU_Out), .CarryOut(CarryOut)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [8:0] got, input logic [8:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got carry/out=%h expected=%h", tag, got, exp);
        end
    endtask

    // Independent reference: {carry, result}
    function automatic logic [8:0] model(input logic [7:0] a, input logic [7:0] b, input logic [3:0] s);
        int ia, ib, r;
        ia = a; ib = b;
        case (s)
            4'd0:  r = ia + ib;
            4'd1:  r = ia - ib + 256;
            4'd2:  r = ia * ib;
            4'd3:  r = (ib == 0) ? 255 : ia / ib;
            4'd4:  r = ia * 2;
            4'd5:  r = ia / 2;
            4'd6:  r = ia * 2 + ia / 128;
            4'd7:  r = ia / 2 + (ia % 2) * 128;
            4'd8:  r = ia & ib;
            4'd9:  r = ia | ib;
            4'd10: r = ia ^ ib;
            4'd11: r = 255 - (ia | ib);
            4'd12: r = 255 - (ia & ib);
            4'd13: r = 255 - (ia ^ ib);
            4'd14: r = (ia > ib) ? 1 : 0;
            default: r = (ia == ib) ? 1 : 0;
        endcase
        model = {((ia + ib) > 255) ? 1'b1 : 1'b0, 8'(r % 256)};
    endfunction

    task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic [3:0] s, input logic [8:0] exp);
        @(negedge clk);
        A = a; B = b; ALU_Sel = s;
        sb.push_back(exp);
    endtask

    // Monitor: compare each registered result against the oldest pending expectation
    always @(posedge clk) begin
        #1;
        if (rst_n && sb.size() > 0) check("result", {CarryOut, ALU_Out}, sb.pop_front());
    end

    logic [7:0] sweep [16] = '{8'hFF, 8'h55, 8'h72, 8'h02, 8'h54, 8'h55, 8'h55, 8'h55,
                               8'h00, 8'hFF, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'h01, 8'h00};

    initial begin
        A = 8'hAA; B = 8'h55;
        repeat (3) @(posedge clk);
        #1 check("reset_hold", {CarryOut, ALU_Out}, 9'h000);
        @(negedge clk);
        rst_n = 1'b1;
        ALU_Sel = 4'h0;
        sb.push_back(9'h0FF);
        for (int i = 0; i < 16; i++) begin
            drive(8'hAA, 8'h55, 4'(i), {1'b0, sweep[i]});
            if (i == 9) begin
                @(posedge clk);
                #3 rst_n = 1'b0;
                #1 check("async_reset", {CarryOut, ALU_Out}, 9'h000);
                @(posedge clk);
                #1 check("reset_held_edge", {CarryOut, ALU_Out}, 9'h000);
                @(negedge clk);
                rst_n = 1'b1;
            end
        end
        drive(8'hFF, 8'h01, 4'b0000, 9'h100);
        drive(8'hFF, 8'h01, 4'b1000, 9'h101);
        drive(8'h00, 8'h01, 4'b0001, 9'h0FF);
        drive(8'h10, 8'h10, 4'b0010, 9'h000);
        drive(8'h37, 8'h00, 4'b0011, 9'h0FF);
        drive(8'h81, 8'h00, 4'b0110, 9'h003);
        drive(8'h81, 8'h00, 4'b0111, 9'h0C0);
        drive(8'h5A, 8'h5A, 4'b1110, 9'h000);
        drive(8'h5A, 8'h5A, 4'b1111, 9'h001);
        drive(8'h5B, 8'h5A, 4'b1110, 9'h001);
        drive(8'h5B, 8'h5A, 4'b1111, 9'h000);
        // Inputs changed between edges must not disturb the held result
        @(posedge clk);
        #3 A = 8'h00; B = 8'h00; ALU_Sel = 4'b1001;
        #1 check("hold_between_edges", {CarryOut, ALU_Out}, 9'h000);
        for (int i = 0; i < 48; i++) begin
            logic [7:0] a, b;
            logic [3:0] s;
            a = 8'($urandom_range(0, 255));
            b = (i % 8 == 0) ? 8'h00 : 8'($urandom_range(0, 255));
            s = 4'(i % 16);
            drive(a, b, s, model(a, b, s));
        end
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() > 0) check("drain_timeout", 9'(sb.size()), 9'h000);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
